// File: rtl/mmio_bridge_pkg.sv
// Shared constants and helpers for the miniLA MMIO bridge: register offsets,
// default I/O window base and the hex-to-7-segment lookup.
package mmio_bridge_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_F000;

  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [2:0] {
    SEL_DRAM,
    SEL_NONE,
    SEL_DIG,
    SEL_TIMER,
    SEL_LED,
    SEL_SW
  } reg_sel_e;

  // Active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_bridge_seg7_scan.sv
// Time-multiplexed 8-digit 7-segment scanner driven by the DIG register.
// Outputs are registered and active-low; dp is always off.
module seg7_scan
  import mmio_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dig_i,
  output logic [7:0]  dig_en_o,
  output logic [7:0]  dig_seg_o
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       en_q, en_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       nib;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Outputs follow the next index so enable and segments switch together.
  assign nib   = dig_i[{idx_d, 2'b00} +: 4];
  assign en_d  = ~(8'b1 << idx_d);
  assign seg_d = {1'b1, ~hex7seg(nib)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      idx_q <= '0;
      en_q  <= 8'hFE;
      seg_q <= 8'hC0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      en_q  <= en_d;
      seg_q <= seg_d;
    end
  end

  assign dig_en_o  = en_q;
  assign dig_seg_o = seg_q;

endmodule

// File: rtl/mmio_bridge.sv
// Data-bus decoder for the miniLA core: steers MEM-stage accesses to data RAM
// or the I/O window and owns the LED, DIG, TIMER and SW registers.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
  parameter int          SCAN_DIV = 20000,
  parameter int          DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic [3:0]         Bus_we,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [3:0]         dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic     is_io;
  reg_sel_e sel;

  logic [31:0] dig_q, dig_d;
  logic [31:0] tmr_q, tmr_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_s1_q, sw_s2_q;

  logic [31:0] dig_mrg, tmr_mrg, led_mrg, led_ext;

  assign is_io = (Bus_addr[31:12] == IO_BASE[31:12]);

  always_comb begin
    sel = SEL_DRAM;
    if (is_io) begin
      case (Bus_addr[11:0])
        OFF_DIG:   sel = SEL_DIG;
        OFF_TIMER: sel = SEL_TIMER;
        OFF_LED:   sel = SEL_LED;
        OFF_SW:    sel = SEL_SW;
        default:   sel = SEL_NONE;
      endcase
    end
  end

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_we    = is_io ? 4'b0000 : Bus_we;
  assign dram_wdata = Bus_wdata;

  assign led_ext = {8'h00, led_q};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign dig_mrg[l*LANE_W +: LANE_W] = Bus_we[l] ? Bus_wdata[l*LANE_W +: LANE_W]
                                                   : dig_q[l*LANE_W +: LANE_W];
    assign tmr_mrg[l*LANE_W +: LANE_W] = Bus_we[l] ? Bus_wdata[l*LANE_W +: LANE_W]
                                                   : tmr_q[l*LANE_W +: LANE_W];
    assign led_mrg[l*LANE_W +: LANE_W] = Bus_we[l] ? Bus_wdata[l*LANE_W +: LANE_W]
                                                   : led_ext[l*LANE_W +: LANE_W];
  end

  // A pure read of TIMER (no lanes enabled) must keep counting.
  always_comb begin
    dig_d = (sel == SEL_DIG) ? dig_mrg : dig_q;
    led_d = (sel == SEL_LED) ? led_mrg[23:0] : led_q;
    tmr_d = tmr_q + 32'd1;
    if (sel == SEL_TIMER && |Bus_we) tmr_d = tmr_mrg;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      dig_q   <= '0;
      tmr_q   <= '0;
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      dig_q   <= dig_d;
      tmr_q   <= tmr_d;
      led_q   <= led_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_comb begin
    Bus_rdata = '0;
    case (sel)
      SEL_DRAM:  Bus_rdata = dram_rdata;
      SEL_DIG:   Bus_rdata = dig_q;
      SEL_TIMER: Bus_rdata = tmr_q;
      SEL_LED:   Bus_rdata = {8'h00, led_q};
      SEL_SW:    Bus_rdata = {8'h00, sw_s2_q};
      default:   Bus_rdata = '0;
    endcase
  end

  assign led = led_q;

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk_i    (cpu_clk),
    .rst_ni   (cpu_rst),
    .dig_i    (dig_q),
    .dig_en_o (dig_en),
    .dig_seg_o(dig_seg)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mmio_bridge;

  localparam int SEL_RDATA = 0, SEL_LED = 1, SEL_EN = 2, SEL_SEG = 3,
                 SEL_DADDR = 4, SEL_DWE = 5, SEL_DWDATA = 6;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] Bus_addr = '0;
  logic [3:0]  Bus_we = '0;
  logic [31:0] Bus_wdata = '0;
  logic [31:0] Bus_rdata;
  logic [13:0] dram_addr;
  logic [3:0]  dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic [23:0] sw = '0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  mmio_bridge #(
    .IO_BASE (32'hFFFF_F000),
    .SCAN_DIV(4),
    .DRAM_AW (14)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .Bus_addr  (Bus_addr),
    .Bus_we    (Bus_we),
    .Bus_wdata (Bus_wdata),
    .Bus_rdata (Bus_rdata),
    .dram_addr (dram_addr),
    .dram_we   (dram_we),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .led       (led),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  chk_t cur;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] en_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  function automatic logic [31:0] pick(int s);
    case (s)
      SEL_RDATA:  return Bus_rdata;
      SEL_LED:    return {8'h00, led};
      SEL_EN:     return {24'h0, dig_en};
      SEL_SEG:    return {24'h0, dig_seg};
      SEL_DADDR:  return {18'h0, dram_addr};
      SEL_DWE:    return {28'h0, dram_we};
      default:    return dram_wdata;
    endcase
  endfunction

  task automatic expect_v(input string n, input int s, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.exp  = e;
    sb_q.push_back(c);
  endtask

  // One bus cycle: inputs change just after the rising edge.
  task automatic cyc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    @(posedge cpu_clk);
    #1;
    Bus_addr  = a;
    Bus_we    = we;
    Bus_wdata = wd;
  endtask

  always @(negedge cpu_clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      checks++;
      if (pick(cur.sel) !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cur.name, pick(cur.sel), cur.exp);
      end
    end
  end

  initial begin
    // Power-on reset.
    repeat (2) @(posedge cpu_clk);
    #1;
    expect_v("por_led", SEL_LED, 32'h0);
    expect_v("por_en",  SEL_EN,  32'hFE);
    expect_v("por_seg", SEL_SEG, 32'hC0);
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b1;

    // DRAM pass-through.
    cyc(32'h0000_0104, 4'b0011, 32'h1122_3344);
    dram_rdata = 32'hCAFE_BABE;
    expect_v("dram_addr",  SEL_DADDR,  32'h41);
    expect_v("dram_we",    SEL_DWE,    32'h3);
    expect_v("dram_wdata", SEL_DWDATA, 32'h1122_3344);
    expect_v("dram_rd",    SEL_RDATA,  32'hCAFE_BABE);
    cyc(32'hFFFE_F060, 4'b1111, 32'hFFFF_FFFF);
    dram_rdata = 32'h0BAD_F00D;
    expect_v("near_io_we", SEL_DWE,   32'hF);
    expect_v("near_io_rd", SEL_RDATA, 32'h0BAD_F00D);

    // LED byte write, read-during-write returns old value.
    cyc(32'hFFFF_F060, 4'b0100, 32'h1234_5678);
    expect_v("led_wr_dwe",  SEL_DWE,   32'h0);
    expect_v("led_rdw",     SEL_RDATA, 32'h0);
    expect_v("led_pre",     SEL_LED,   32'h0);
    cyc(32'hFFFF_F060, 4'b0000, 32'h0);
    expect_v("led_lane2",   SEL_LED,   32'h0034_0000);
    expect_v("led_rd",      SEL_RDATA, 32'h0034_0000);
    cyc(32'hFFFF_F060, 4'b1111, 32'hFFFF_FFFF);
    cyc(32'hFFFF_F060, 4'b0000, 32'h0);
    expect_v("led_lane3",   SEL_RDATA, 32'h00FF_FFFF);

    // Unmapped offset and read-only SW.
    cyc(32'hFFFF_F040, 4'b1111, 32'hDEAD_BEEF);
    expect_v("unmap_rdw",   SEL_RDATA, 32'h0);
    cyc(32'hFFFF_F040, 4'b0000, 32'h0);
    expect_v("unmap_rd",    SEL_RDATA, 32'h0);
    cyc(32'hFFFF_F070, 4'b1111, 32'hFFFF_FFFF);
    cyc(32'hFFFF_F070, 4'b0000, 32'h0);
    expect_v("sw_ro",       SEL_RDATA, 32'h0);

    // Timer load, wrap and byte-merged load.
    cyc(32'hFFFF_F020, 4'b1111, 32'hFFFF_FFFE);
    cyc(32'hFFFF_F020, 4'b0000, 32'h0);
    expect_v("tmr_load",    SEL_RDATA, 32'hFFFF_FFFE);
    cyc(32'hFFFF_F020, 4'b0000, 32'h0);
    expect_v("tmr_max",     SEL_RDATA, 32'hFFFF_FFFF);
    cyc(32'hFFFF_F020, 4'b0000, 32'h0);
    expect_v("tmr_wrap",    SEL_RDATA, 32'h0);
    cyc(32'hFFFF_F020, 4'b0001, 32'h0000_00AB);
    expect_v("tmr_rdw",     SEL_RDATA, 32'h1);
    cyc(32'hFFFF_F020, 4'b0000, 32'h0);
    expect_v("tmr_merge",   SEL_RDATA, 32'h0000_00AB);
    cyc(32'hFFFF_F020, 4'b0000, 32'h0);
    expect_v("tmr_count",   SEL_RDATA, 32'h0000_00AC);

    // Switch synchroniser latency.
    cyc(32'hFFFF_F070, 4'b0000, 32'h0);
    sw = 24'hA5A5A5;
    expect_v("sw_old0",     SEL_RDATA, 32'h0);
    cyc(32'hFFFF_F070, 4'b0000, 32'h0);
    expect_v("sw_old1",     SEL_RDATA, 32'h0);
    cyc(32'hFFFF_F070, 4'b0000, 32'h0);
    expect_v("sw_new",      SEL_RDATA, 32'h00A5_A5A5);
    sw = 24'hFFFFFF;
    cyc(32'hFFFF_F070, 4'b0000, 32'h0);
    expect_v("sw_old2",     SEL_RDATA, 32'h00A5_A5A5);
    cyc(32'hFFFF_F070, 4'b0000, 32'h0);
    expect_v("sw_full",     SEL_RDATA, 32'h00FF_FFFF);

    // Mid-operation reset.
    @(posedge cpu_clk);
    #1;
    cpu_rst   = 1'b0;
    Bus_addr  = 32'hFFFF_F020;
    Bus_we    = 4'b0000;
    expect_v("rst_led",     SEL_LED,   32'h0);
    expect_v("rst_en",      SEL_EN,    32'hFE);
    expect_v("rst_seg",     SEL_SEG,   32'hC0);
    expect_v("rst_tmr",     SEL_RDATA, 32'h0);

    // Scan: cycle t counts from reset release; idx advances every 4 cycles.
    for (int t = 0; t < 36; t++) begin
      @(posedge cpu_clk);
      #1;
      if (t == 0) begin
        cpu_rst = 1'b1;
        expect_v("post_rst_tmr", SEL_RDATA, 32'h0);
      end else if (t == 1) begin
        Bus_addr  = 32'hFFFF_F000;
        Bus_we    = 4'b1111;
        Bus_wdata = 32'h7654_3210;
      end else begin
        Bus_addr  = 32'hFFFF_F000;
        Bus_we    = 4'b0000;
        if (t == 2) expect_v("dig_rd", SEL_RDATA, 32'h7654_3210);
      end
      expect_v($sformatf("scan_en_t%0d", t),  SEL_EN,  {24'h0, en_tab[(t/4)%8]});
      expect_v($sformatf("scan_seg_t%0d", t), SEL_SEG, {24'h0, seg_tab[(t/4)%8]});
    end

    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
